window_frame_feeder: RTL and testbench
======================================

Name: window_frame_feeder

Overview:
- Producer side of the windowing interface: sits between the low-pass filter output and hanning_window.
- Buffers the continuous filtered sample stream in a ring buffer and emits overlapping frames of N samples.
- Each emitted sample is tagged with its 0..N-1 frame position so the window stage can look up its coefficient directly.
- Consecutive frames start HOP samples apart, so frames overlap by N-HOP samples.

Parameters:
- W, 16, sample width in bits.
- N, 1024, frame length; power of two.
- MAX_SAMPLE_INDEX, 9, MSB of the frame index; log2(N)-1.
- HOP, 512, samples between consecutive frame starts; 1 <= HOP <= N.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  filtered sample present.
- in_ready  out  1  feeder can accept a sample.
- in_sample  in  W  filtered sample, two's complement.
- out_valid  out  1  out_sample/out_index valid.
- out_ready  in  1  window stage accepts the sample.
- out_sample  out  W  frame sample.
- out_index  out  MAX_SAMPLE_INDEX+1  position in frame, 0..N-1.
- out_last  out  1  high with index N-1.
- busy  out  1  frame emission in progress.
- overflow  out  1  sticky drop flag; tied 0 when the optional feature is off.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pointers and counts cleared; state IDLE.
  - out_valid=0, out_sample=0, out_index=0, out_last=0, busy=0, overflow=0.
  - in_ready=1 on the first clock edge after release.
  - Buffer contents are don't-care.
  - Asserting reset mid-frame aborts the frame immediately; no partial frame is resumed after release.
- Storage:
  - Ring buffer of depth 2N, synchronous-read RAM.
  - Pointers: wr_ptr, frame_start, rd_ptr, each log2(2N) bits; wrap modulo 2N.
  - count = samples from frame_start up to wr_ptr, range 0..2N.
- Write side:
  - in_ready = (count < 2N).
  - A sample is written when in_valid && in_ready; wr_ptr+1, count+1.
  - Writes continue during emission. Samples of the current frame are never overwritten, because count counts from frame_start.
- States:
  - IDLE: busy=0. Go to PRIME when count >= N.
  - PRIME: one cycle. RAM read issued at frame_start; rd_ptr=frame_start+1; busy=1.
  - STREAM:
    - Output register loads the RAM data with out_index=k.
    - Hold rule: while out_valid && !out_ready, out_sample, out_index and out_last are held stable and no new RAM read is issued.
    - With out_ready held high, exactly one sample is transferred per cycle with no bubbles (prefetch/skid as needed).
    - out_index counts 0..N-1; out_last=1 only with index N-1.
    - When index N-1 is transferred (out_valid && out_ready): out_valid=0 next cycle, state DONE.
  - DONE: one cycle.
    - frame_start += HOP (mod 2N).
    - count = count - HOP, plus 1 if a write occurs in the same cycle.
    - Next state PRIME if the updated count >= N, else IDLE.
- Latency: first out_valid is 2 cycles after count first reaches N in IDLE (PRIME, then output register).
- Simultaneous events: a write and a frame retirement in the same cycle net to count + 1 - HOP. No sample is lost and count is never double-counted.
- Full: count == 2N gives in_ready=0. Emission continues, and in_ready returns the cycle after DONE.
- Arithmetic: samples pass through unmodified; no rounding or sign change.

Optional Feature:
- Macro: FEEDER_DROP_ON_FULL_EN.
- When defined:
  - in_ready is tied to 1.
  - A sample arriving while count == 2N is discarded: no pointer or count change.
  - overflow is set to 1 and stays high until reset.
- When undefined:
  - in_ready follows the full rule above (backpressure).
  - overflow is constant 0.

Test Plan (N=8, MAX_SAMPLE_INDEX=2, HOP=4, W=16):
- Write 0x0001..0x0008 with out_ready=1 -> out_valid 2 cycles after 8th write; 8 back-to-back outputs 0x0001..0x0008, index 0..7, out_last only on 0x0008.
- Continue writing 0x0009..0x000C -> second frame 0x0005..0x000C, index 0..7 (overlap of 4 samples verified).
- Hold out_ready=0 for 5 cycles at index 3 -> out_sample/out_index/out_last stable; resumes at index 3, no sample skipped or repeated.
- out_ready=0 while writing 20 samples -> in_ready falls after 16 buffered; no write accepted while low; after release, frames emit correctly. With FEEDER_DROP_ON_FULL_EN: in_ready stays 1, 17th sample dropped, overflow=1 and sticky.
- Write lands in the same cycle as DONE -> count = prior+1-4; next frame starts at old frame_start+4 with correct data.
- Assert reset at index 5 -> all outputs 0 immediately (asynchronous); after release, 8 new samples produce a fresh frame from index 0.

Source files
------------

// File: rtl/window_frame_feeder.sv
// Ring-buffered frame feeder: turns a sample stream into overlapping N-sample frames tagged with position.
// Optional FEEDER_DROP_ON_FULL_EN: never backpressure, drop samples when full and raise sticky overflow.
module window_frame_feeder #(
    parameter int W                = 16,
    parameter int N                = 1024,
    parameter int MAX_SAMPLE_INDEX = 9,
    parameter int HOP              = 512
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_sample,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_sample,
    output logic [MAX_SAMPLE_INDEX:0] out_index,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overflow
);
    localparam int IW = MAX_SAMPLE_INDEX + 1;
    localparam int AW = IW + 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(2 * N);
    localparam logic [CW-1:0] NLEN     = CW'(N);
    localparam logic [CW-1:0] HOP_C    = CW'(HOP);
    localparam logic [AW-1:0] HOP_A    = AW'(HOP);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [IW-1:0] ONE_I    = IW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  fs_q, fs_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           vld_q, vld_d;
    logic [W-1:0]   dout_q;
    logic [W-1:0]   mem [2*N];
    logic           full, wr_en, rd_en;
    logic [AW-1:0]  rd_addr;

    assign full = (count_q == DEPTH);

`ifdef FEEDER_DROP_ON_FULL_EN
    logic ovf_q;
    assign in_ready = 1'b1;
    assign wr_en    = in_valid && !full;
    assign overflow = ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               ovf_q <= 1'b0;
        else if (in_valid && full) ovf_q <= 1'b1;
    end
`else
    assign in_ready = !full;
    assign wr_en    = in_valid && !full;
    assign overflow = 1'b0;
`endif

    // The RAM read register doubles as the output register: it only reloads on a
    // read, and reads are suppressed while the consumer stalls, so data holds.
    assign out_valid  = vld_q;
    assign out_sample = dout_q;
    assign out_index  = idx_q;
    assign out_last   = vld_q && (idx_q == LAST_IDX);
    assign busy       = (state_q != IDLE);
    assign wr_ptr_d   = wr_en ? wr_ptr_q + ONE_A : wr_ptr_q;

    always_comb begin
        state_d  = state_q;
        fs_d     = fs_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        vld_d    = vld_q;
        rd_en    = 1'b0;
        rd_addr  = rd_ptr_q;
        count_d  = count_q + CW'(wr_en);
        case (state_q)
            IDLE: begin
                if (count_q >= NLEN) state_d = PRIME;
            end
            PRIME: begin
                rd_en    = 1'b1;
                rd_addr  = fs_q;
                rd_ptr_d = fs_q + ONE_A;
                idx_d    = '0;
                vld_d    = 1'b1;
                state_d  = STREAM;
            end
            STREAM: begin
                if (vld_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        rd_en    = 1'b1;
                        rd_ptr_d = rd_ptr_q + ONE_A;
                        idx_d    = idx_q + ONE_I;
                    end
                end
            end
            DONE: begin
                // A write landing here is folded into the same update as the retirement.
                fs_d    = fs_q + HOP_A;
                count_d = count_q + CW'(wr_en) - HOP_C;
                state_d = (count_d >= NLEN) ? PRIME : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            fs_q     <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fs_q     <= fs_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            if (rd_en) dout_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_sample;
    end
endmodule

// File: tb/tb_window_frame_feeder.sv
// Directed bench for window_frame_feeder at N=8, HOP=4 with immediate-assertion checks.
module tb_window_frame_feeder;
    logic        clk, reset, in_valid, in_ready, out_valid, out_ready, out_last, busy, overflow;
    logic [15:0] in_sample, out_sample;
    logic [2:0]  out_index;
    int          n_cmp, n_err;

    window_frame_feeder #(.W(16), .N(8), .MAX_SAMPLE_INDEX(2), .HOP(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .out_valid(out_valid), .out_ready(out_ready),
        .out_sample(out_sample), .out_index(out_index), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] v);
        in_valid  = 1'b1;
        in_sample = v;
        tick();
        in_valid  = 1'b0;
    endtask

    // Consumes one frame of consecutive values first..first+7, optionally stalling 5 cycles at stall_at.
    task automatic expect_frame(input logic [15:0] first, input int stall_at);
        int t;
        t = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        chk("frame_valid", 32'(out_valid), 32'd1);
        if (out_valid !== 1'b1) return;
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_sample", 32'(out_sample), 32'(first) + 32'(k));
                    chk("hold_index", 32'(out_index), 32'(k));
                    chk("hold_last", 32'(out_last), 32'(k == 7));
                end
                out_ready = 1'b1;
            end
            chk("sample", 32'(out_sample), 32'(first) + 32'(k));
            chk("index", 32'(out_index), 32'(k));
            chk("last", 32'(out_last), 32'(k == 7));
            tick();
        end
        chk("frame_end_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int t;
        n_cmp = 0; n_err = 0;
        reset = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sample", 32'(out_sample), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // First frame and its two-cycle start latency
        for (int i = 1; i <= 8; i++) wr(16'(i));
        chk("lat_idle_valid", 32'(out_valid), 32'd0);
        chk("lat_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("lat_prime_valid", 32'(out_valid), 32'd0);
        chk("lat_prime_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        expect_frame(16'h0001, -1);

        // Overlapping second frame with a 5-cycle stall at index 3
        for (int i = 9; i <= 12; i++) wr(16'(i));
        expect_frame(16'h0005, 3);

        // Frame 9..16, then a write landing in the DONE cycle
        for (int i = 13; i <= 16; i++) wr(16'(i));
        expect_frame(16'h0009, -1);
        wr(16'd17);
        wr(16'd18);
        wr(16'd19);
        repeat (4) tick();
        chk("done_wr_no_early_frame", 32'(busy), 32'd0);
        wr(16'd20);
        expect_frame(16'h000D, -1);

        // Asynchronous reset in the middle of a frame
        for (int i = 21; i <= 24; i++) wr(16'(i));
        t = 0;
        while (out_valid !== 1'b1 && t < 40) begin tick(); t++; end
        chk("mid_frame_valid", 32'(out_valid), 32'd1);
        repeat (5) tick();
        chk("mid_frame_index", 32'(out_index), 32'd5);
        chk("mid_frame_sample", 32'(out_sample), 32'd22);
        #3 reset = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_sample", 32'(out_sample), 32'd0);
        chk("async_index", 32'(out_index), 32'd0);
        chk("async_last", 32'(out_last), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        #20;
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i));
        expect_frame(16'h0100, -1);

        // Fill past capacity while the consumer is stalled
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_sample = 16'h0200 + 16'(i);
`ifdef FEEDER_DROP_ON_FULL_EN
            chk("drop_in_ready", 32'(in_ready), 32'd1);
            chk("drop_overflow", 32'(overflow), 32'(i > 16));
`else
            chk("full_in_ready", 32'(in_ready), 32'(i < 16));
`endif
            tick();
        end
        in_valid = 1'b0;
        expect_frame(16'h0200, -1);
`ifdef FEEDER_DROP_ON_FULL_EN
        chk("done_in_ready", 32'(in_ready), 32'd1);
`else
        chk("done_in_ready", 32'(in_ready), 32'd0);
`endif
        tick();
        chk("post_done_in_ready", 32'(in_ready), 32'd1);
        expect_frame(16'h0204, -1);
        expect_frame(16'h0208, -1);
        repeat (4) tick();
        chk("full_drained_busy", 32'(busy), 32'd0);
`ifdef FEEDER_DROP_ON_FULL_EN
        chk("overflow_sticky", 32'(overflow), 32'd1);
`else
        chk("overflow_off", 32'(overflow), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
